// File: rtl/noc_port_rx.sv
// -----------------------------------------------------------------------------
// noc_port_rx
//
// Receive side of a NoC port. Flits arriving from the network interface are
// parsed into packets (header, 1-4 data flits, 8'hFF trailer), written into a
// small flit FIFO and steered to one of four destinations. Malformed traffic is
// dropped up to the next 8'hFF. A missing trailer after four data flits is
// repaired by writing a synthesized trailer.
//
// Parameters
//   FIFO_DEPTH  number of flit buffer entries (power of two, >= 2)
//   HEADER_ID   expected value of header bits [7:2]
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_flit/in_valid       flit from the NI
//   in_ready               port can accept a flit
//   out_flit/out_last      FIFO head flit and its trailer marker
//   out_valid[3:0]         one-hot valid toward the selected destination
//   out_ready[3:0]         per-destination accept
//   hdr_err, frm_err       one-cycle error pulses (bad header, missing trailer)
//   pkt_count, err_count   saturating statistics counters
//
// Configuration
//   NOC_RX_STATS_EN  when defined, pkt_count/err_count are live counters;
//                    otherwise they are tied to zero and no flops are built.
// -----------------------------------------------------------------------------
module noc_port_rx #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [5:0]  HEADER_ID  = 6'b101111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_flit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_flit,
  output logic       out_last,
  output logic [3:0] out_valid,
  input  logic [3:0] out_ready,
  output logic       hdr_err,
  output logic       frm_err,
  output logic [7:0] pkt_count,
  output logic [7:0] err_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_HEAD = 2'd0;
  localparam logic [1:0] ST_BODY = 2'd1;
  localparam logic [1:0] ST_TAIL = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  localparam logic [7:0]  TRAILER  = 8'hFF;
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  typedef struct packed {
    logic       hd;
    logic       last;
    logic [7:0] flit;
  } entry_t;

  // Input parser state
  logic [1:0] state_q, state_d;
  logic [2:0] dcnt_q, dcnt_d;

  // Flit buffer
  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full, empty;
  logic          push, pop;
  entry_t        push_entry;
  entry_t        head;

  // Routing and error pulses
  logic [1:0] route_q, cur_dest;
  logic       hdr_err_d, frm_err_d;
  logic       hdr_err_q, frm_err_q;
  logic       in_xfer;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // DROP swallows flits without writing, so it never backpressures.
  assign in_ready = (state_q == ST_DROP) || !full;
  assign in_xfer  = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Input parser: decides what (if anything) is written for each accepted flit.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    dcnt_d     = dcnt_q;
    push       = 1'b0;
    push_entry = '{hd: 1'b0, last: 1'b0, flit: in_flit};
    hdr_err_d  = 1'b0;
    frm_err_d  = 1'b0;

    if (in_xfer) begin
      case (state_q)
        ST_HEAD: begin
          if (in_flit[7:2] == HEADER_ID) begin
            push          = 1'b1;
            push_entry.hd = 1'b1;
            state_d       = ST_BODY;
            dcnt_d        = 3'd0;
          end else begin
            hdr_err_d = 1'b1;
            state_d   = ST_DROP;
          end
        end

        ST_BODY: begin
          push = 1'b1;
          if (dcnt_q == 3'd0) begin
            // The first data flit is payload even if it looks like a trailer.
            dcnt_d = 3'd1;
          end else if (in_flit == TRAILER) begin
            push_entry.last = 1'b1;
            state_d         = ST_HEAD;
            dcnt_d          = 3'd0;
          end else begin
            dcnt_d = dcnt_q + 3'd1;
            if (dcnt_q == 3'd3) begin
              state_d = ST_TAIL;
            end
          end
        end

        ST_TAIL: begin
          // Always close the packet in the buffer; a wrong flit here is
          // replaced by a synthesized trailer and the rest is discarded.
          push       = 1'b1;
          push_entry = '{hd: 1'b0, last: 1'b1, flit: TRAILER};
          state_d    = ST_HEAD;
          dcnt_d     = 3'd0;
          if (in_flit != TRAILER) begin
            frm_err_d = 1'b1;
            state_d   = ST_DROP;
          end
        end

        default: begin
          if (in_flit == TRAILER) begin
            state_d = ST_HEAD;
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_HEAD;
      dcnt_q    <= 3'd0;
      hdr_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      hdr_err_q <= hdr_err_d;
      frm_err_q <= frm_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Flit FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only observed while the
  // occupancy says they hold data, and resetting the pointers empties it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_entry;
    end
  end

  assign head = mem[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Output routing: a header names its own destination; the body and trailer
  // follow the destination latched when that header left the FIFO.
  // ---------------------------------------------------------------------------
  assign cur_dest  = head.hd ? head.flit[1:0] : route_q;
  assign out_valid = empty ? 4'b0000 : (4'b0001 << cur_dest);
  assign out_flit  = empty ? 8'h00 : head.flit;
  assign out_last  = !empty && head.last;
  assign pop       = |(out_valid & out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      route_q <= 2'd0;
    end else if (pop && head.hd) begin
      route_q <= head.flit[1:0];
    end
  end

  assign hdr_err = hdr_err_q;
  assign frm_err = frm_err_q;

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef NOC_RX_STATS_EN
  logic [7:0] pkt_count_q, err_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count_q <= 8'd0;
      err_count_q <= 8'd0;
    end else begin
      if (pop && head.last && (pkt_count_q != 8'hFF)) begin
        pkt_count_q <= pkt_count_q + 8'd1;
      end
      if ((hdr_err_q || frm_err_q) && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign pkt_count = pkt_count_q;
  assign err_count = err_count_q;
`else
  assign pkt_count = 8'd0;
  assign err_count = 8'd0;
`endif

endmodule

// File: doc/noc_port_rx.md
NOC_PORT_RX -- requirements
Module: noc_port_rx

Interface
REQ-001 SHALL have the parameter FIFO_DEPTH, default 4, giving the number of flit buffer entries (power of two, at least 2).
REQ-002 SHALL have the parameter HEADER_ID, default 6'b101111, giving the expected value of header bits [7:2].
REQ-003 SHALL have one clock and an asynchronous active-low reset; all state changes on the rising edge of clk. Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_flit  in  8  flit from the NI
- in_valid  in  1  in_flit is valid
- in_ready  out  1  port can accept a flit (the NI samples it as noc_ready)
- out_flit  out  8  flit at the FIFO head
- out_last  out  1  out_flit is a trailer
- out_valid  out  4  one-hot flit-valid per destination
- out_ready  in  4  per-destination accept
- hdr_err  out  1  one-cycle pulse: bad header
- frm_err  out  1  one-cycle pulse: framing error
- pkt_count  out  8  count of completed packets
- err_count  out  8  count of errors

Function
REQ-004 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid[d] && out_ready[d].
REQ-005 A packet SHALL be: header {HEADER_ID, dest[1:0]}, then 1-4 data flits, then trailer 8'hFF.
REQ-006 The input FSM SHALL have the states HEAD, BODY, TAIL, DROP, plus a data counter dcnt[2:0].
REQ-007 HEAD: if in_flit[7:2]==HEADER_ID, push the flit with hd=1 and go to BODY with dcnt=0; otherwise drop the flit, pulse hdr_err, and go to DROP.
REQ-008 BODY, dcnt==0: push as data, dcnt=1. The first data flit SHALL always be data, even when it is 8'hFF.
REQ-009 BODY, dcnt in 1..3: if the flit is 8'hFF, push it with last=1 and go to HEAD; otherwise push it as data and increment dcnt. When dcnt reaches 4, go to TAIL.
REQ-010 TAIL: if the flit is 8'hFF, push it with last=1 and go to HEAD. Otherwise push a synthesized 8'hFF with last=1 in place of the flit, pulse frm_err, and go to DROP.
REQ-011 DROP: in_ready=1; discard flits until 8'hFF is consumed, then go to HEAD. DROP SHALL write nothing to the FIFO.
REQ-012 Outside DROP, in_ready SHALL equal !full, computed from the registered occupancy only. A pop in the same cycle SHALL NOT enable a push when full.
REQ-013 Each FIFO entry SHALL be {hd, last, flit} (10 bits). Pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop when neither full nor empty SHALL leave occupancy unchanged.
REQ-014 Output routing:
- cur_dest = head entry's flit[1:0] if hd=1, else route_q.
- out_valid[i] = !empty && i==cur_dest; at most one bit set.
- out_flit and out_last come from the head entry.
- route_q SHALL load flit[1:0] when a header entry is popped.
REQ-015 Pass-through latency SHALL be one cycle: a flit pushed at edge N is presented on the output after edge N when the FIFO was empty.
REQ-016 Output backpressure SHALL stall only the FIFO head; no flit is lost or reordered.
REQ-017 hdr_err and frm_err SHALL be registered pulses asserted for exactly one cycle per event.

Reset
REQ-018 While rst_n=0, all of the following SHALL hold:
- FSM = HEAD, dcnt=0, route_q=0
- FIFO empty, in_ready=1
- out_valid=0, out_flit=0, out_last=0
- hdr_err=frm_err=0, counters=0
REQ-019 Reset asserted mid-packet SHALL discard all buffered flits. The first flit after release SHALL be treated as a header.

Configuration
REQ-020 With macro NOC_RX_STATS_EN defined:
- pkt_count SHALL increment on each popped entry with last=1.
- err_count SHALL increment on each hdr_err or frm_err pulse.
- Both counters SHALL saturate at 8'hFF.
REQ-021 Without NOC_RX_STATS_EN, pkt_count and err_count SHALL be tied to 0 and no counter flops SHALL be built; all other behaviour is identical.

Verification
REQ-022 BC (header 8'hBD, dest 1), 8'h12, 8'h34, 8'hFF, out_ready=4'hF → out_valid=4'b0010 for 4 flits; out_last only on 8'hFF.
REQ-023 8'hBC, 8'hFF, 8'hFF → the first 8'hFF is forwarded as data, the second as trailer; 3 flits delivered on out_valid[0].
REQ-024 8'hBF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h55 → 5 flits plus a synthesized 8'hFF with last=1; frm_err pulses once; following flits are dropped until 8'hFF.
REQ-025 8'h3C, 8'hAA, 8'hFF, then a valid packet → hdr_err pulses once; nothing is output until the valid header; err_count=1 with NOC_RX_STATS_EN.
REQ-026 out_ready=0 while 6 flits are offered (FIFO_DEPTH=4) → in_ready falls after 4 pushes. Then raise out_ready → all 6 delivered in order, and in_ready returns the cycle after the first pop.
REQ-027 rst_n pulsed low after the header plus 2 data flits → FIFO empty, out_valid=0; the next 8'hBE is accepted as a header routed to out_valid[2].
